// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA framebuffer write path.
// The display-side read path reuses fb_wr_t and the geometry defaults.
package vga_pkg;

  localparam int unsigned VGA_FB_WIDTH  = 640;
  localparam int unsigned VGA_FB_HEIGHT = 480;
  localparam int unsigned VGA_PXL_W     = 12;
  localparam int unsigned VGA_ADDR_W    = 19;
  localparam int unsigned FB_PIXELS     = VGA_FB_WIDTH * VGA_FB_HEIGHT;

  localparam logic [31:0] VGA_FB_BASE   = 32'h8000_0000;
  localparam logic [31:0] CTRL_OFFSET   = 32'h0010_0000;

  localparam int unsigned CTRL_START_BIT = 31;
  localparam int unsigned CTRL_ABORT_BIT = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  typedef struct packed {
    logic                  we;
    logic [VGA_ADDR_W-1:0] addr;
    logic [VGA_PXL_W-1:0]  data;
  } fb_wr_t;

  function automatic logic fb_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/vga_fill_engine.sv
// Fill engine: pixel counter, latched fill colour and terminal-index detect.
// A pause cycle holds the counter so the CPU can own the write port.
module vga_fill_engine
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W = VGA_ADDR_W,
  parameter int unsigned PXL_W  = VGA_PXL_W,
  parameter int unsigned PIXELS = FB_PIXELS
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [PXL_W-1:0]  colour_i,
  input  logic              active_i,
  input  logic              pause_i,
  output logic              fill_we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [PXL_W-1:0]  colour_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIXELS - 1);

  logic [ADDR_W-1:0] count_q, count_d;
  logic [PXL_W-1:0]  colour_q, colour_d;
  logic              fill_we_s;

  assign fill_we_s = active_i & ~pause_i;

  // Counter and colour next-state.
  always_comb begin
    count_d  = count_q;
    colour_d = colour_q;
    if (start_i) begin
      count_d  = {ADDR_W{1'b0}};
      colour_d = colour_i;
    end else if (fill_we_s) begin
      count_d  = count_q + ADDR_W'(1);
    end else begin
      count_d  = count_q;
    end
  end

  // Counter and colour registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q  <= {ADDR_W{1'b0}};
      colour_q <= {PXL_W{1'b0}};
    end else begin
      count_q  <= count_d;
      colour_q <= colour_d;
    end
  end

  assign fill_we_o = fill_we_s;
  assign addr_o    = count_q;
  assign colour_o  = colour_q;
  assign last_o    = fill_we_s & (count_q == LAST_IDX);

endmodule

// File: rtl/vga_fb_write_ctrl.sv
// Framebuffer write controller: decodes CPU stores, runs the fill engine and
// arbitrates the single framebuffer write port with CPU priority.
module vga_fb_write_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = VGA_FB_WIDTH,
  parameter int unsigned FB_HEIGHT = VGA_FB_HEIGHT,
  parameter int unsigned PXL_W     = VGA_PXL_W,
  parameter logic [31:0] FB_BASE   = VGA_FB_BASE,
  parameter logic [31:0] CTRL_ADDR = VGA_FB_BASE + CTRL_OFFSET,
  parameter int unsigned ADDR_W    = VGA_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpu_valid,
  output logic              o_cpu_ready,
  input  logic [31:0]       i_cpu_addr,
  input  logic [31:0]       i_cpu_data,
  output logic              o_fb_we,
  output logic [ADDR_W-1:0] o_fb_addr,
  output logic [PXL_W-1:0]  o_fb_data,
  output logic              o_busy,
  output logic              o_fill_done,
  output logic              o_err
);

  localparam int unsigned NPIX   = FB_WIDTH * FB_HEIGHT;
  localparam logic [31:0] NPIX_W = 32'(NPIX);

  fill_state_t       state_q, state_d;

  logic [31:0]       offset_s;
  logic              is_ctrl_s, is_pix_s, start_s, abort_s;
  logic              stall_s, accept_s, pix_wr_s, ctrl_wr_s, go_s, drop_s;

  logic              eng_start_s, eng_active_s;
  logic              fill_we_s, fill_last_s;
  logic [ADDR_W-1:0] fill_addr_s;
  logic [PXL_W-1:0]  fill_colour_s;

  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [PXL_W-1:0]  fb_data_q, fb_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              unused_s;

  // Address decode; the control register wins where it overlaps pixel space.
  always_comb begin
    offset_s  = i_cpu_addr - FB_BASE;
    is_ctrl_s = (i_cpu_addr == CTRL_ADDR);
    is_pix_s  = ~is_ctrl_s && (i_cpu_addr >= FB_BASE) && fb_word_aligned(i_cpu_addr)
                && ({2'b00, offset_s[31:2]} < NPIX_W);
    start_s   = i_cpu_data[CTRL_START_BIT];
    abort_s   = i_cpu_data[CTRL_ABORT_BIT];
    stall_s   = i_cpu_valid & is_ctrl_s & start_s & ~abort_s & (state_q == FILL);
    accept_s  = i_cpu_valid & ~stall_s;
    pix_wr_s  = accept_s & is_pix_s;
    ctrl_wr_s = accept_s & is_ctrl_s;
    go_s      = ctrl_wr_s & start_s & ~abort_s;
    drop_s    = accept_s & ~is_pix_s & ~is_ctrl_s;
  end

  assign o_cpu_ready = ~stall_s;
  assign unused_s    = ^{i_cpu_data[29:PXL_W], offset_s[1:0]};

  vga_fill_engine #(
    .ADDR_W (ADDR_W),
    .PXL_W  (PXL_W),
    .PIXELS (NPIX)
  ) u_fill (
    .clk_i    (i_clk),
    .reset_i  (i_reset),
    .start_i  (eng_start_s),
    .colour_i (i_cpu_data[PXL_W-1:0]),
    .active_i (eng_active_s),
    .pause_i  (pix_wr_s),
    .fill_we_o(fill_we_s),
    .addr_o   (fill_addr_s),
    .colour_o (fill_colour_s),
    .last_o   (fill_last_s)
  );

  // Fill FSM next-state; ABORT takes precedence over both START and terminal.
  always_comb begin
    state_d      = state_q;
    eng_start_s  = 1'b0;
    eng_active_s = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (go_s) begin
          state_d     = FILL;
          eng_start_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        eng_active_s = 1'b1;
        if (ctrl_wr_s && abort_s) begin
          state_d = IDLE;
        end else if (fill_last_s) begin
          state_d = DONE;
        end else begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write-port arbitration: an accepted CPU pixel store pre-empts the fill.
  always_comb begin
    fb_we_d   = 1'b0;
    fb_addr_d = {ADDR_W{1'b0}};
    fb_data_d = {PXL_W{1'b0}};
    if (pix_wr_s) begin
      fb_we_d   = 1'b1;
      fb_addr_d = offset_s[ADDR_W+1:2];
      fb_data_d = i_cpu_data[PXL_W-1:0];
    end else if (fill_we_s) begin
      fb_we_d   = 1'b1;
      fb_addr_d = fill_addr_s;
      fb_data_d = fill_colour_s;
    end else begin
      fb_we_d   = 1'b0;
    end
    busy_d = (state_d == FILL);
    done_d = (state_d == DONE);
    err_d  = drop_s;
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      fb_we_q   <= 1'b0;
      fb_addr_q <= {ADDR_W{1'b0}};
      fb_data_q <= {PXL_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fb_we_q   <= fb_we_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_fb_we     = fb_we_q;
  assign o_fb_addr   = fb_addr_q;
  assign o_fb_data   = fb_data_q;
  assign o_busy      = busy_q;
  assign o_fill_done = done_q;
  assign o_err       = err_q;

endmodule
